// File: rtl/fir_out_fifo.sv
// FIR output stage: drops PIPE_LAT warm-up captures, buffers results in a FWFT FIFO on a valid/ready stream.
// Latency: capture one cycle after the strobe, visible the cycle after capture; a push while full with no pop is dropped and counted.
module fir_out_fifo #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int PIPE_LAT = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_strobe,
  input  logic [DATA_W-1:0]          fir_data,
  input  logic                       flush_i,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int WW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [WW-1:0] WU_DONE  = WW'(PIPE_LAT);

  logic              strb_q, strb_d;
  logic [WW-1:0]     wu_q, wu_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic capture, push, pop, full, wr_en, drop_en;

  assign m_valid  = (level_q != '0);
  assign m_data   = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    strb_d     = valid_strobe;
    wu_d       = wu_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    mem_d      = mem_q;
    wr_en      = 1'b0;
    drop_en    = 1'b0;

    // fir_data was updated on the strobe edge, so the registered strobe marks it valid
    capture = strb_q;
    push    = capture && (wu_q == WU_DONE);
    pop     = m_valid && m_ready;
    full    = (level_q == FULL_LVL);

    // Warm-up keeps counting through a flush; only the buffer state is cleared
    if (capture && !push) begin
      wu_d = wu_q + WW'(1);
    end

    if (flush_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      // A pop on the same edge frees the slot, so a full FIFO still accepts the push
      wr_en   = push && (!full || pop);
      drop_en = push && full && !pop;
      if (wr_en) begin
        mem_d[wr_ptr_q] = fir_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      level_d = level_q + LW'(wr_en) - LW'(pop);
      if (drop_en) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      strb_q     <= 1'b0;
      wu_q       <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      strb_q     <= strb_d;
      wu_q       <= wu_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
